// File: rtl/slow_clock_monitor_pkg.sv
// Shared types for the slow-clock monitor: FSM encoding and interval counter width.
package slow_clock_monitor_pkg;

    localparam int CNT_W = 23;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } mon_state_e;

endpackage

// File: rtl/slow_clock_monitor_if.sv
// Status bundle driven by the monitor (master) and observed by the consumer (slave).
interface slow_clock_monitor_if;
    import slow_clock_monitor_pkg::*;

    logic tick_rise;
    logic tick_fall;
    cnt_t half_period;
    logic meas_valid;
    logic locked;
    logic err_fast;
    logic err_slow;
    logic lock_lost;

    modport master (
        output tick_rise, tick_fall, half_period, meas_valid,
        output locked, err_fast, err_slow, lock_lost
    );

    modport slave (
        input tick_rise, tick_fall, half_period, meas_valid,
        input locked, err_fast, err_slow, lock_lost
    );

endinterface

// File: rtl/slow_clock_monitor_sync_edge_detect.sv
// Two-flop synchronizer plus history flop; flags level changes of the async input.
// A fill shift register keeps the first level seen after reset from counting as an edge.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic edge_o,
    output logic tick_rise_o,
    output logic tick_fall_o
);
    logic       sync1_q, sync2_q, hist_q;
    logic [2:0] fill_q;
    logic       tick_rise_q, tick_fall_q;

    // Edge only once history holds a synchronized value, so a high level at reset release is not a rise.
    assign edge_o = fill_q[2] && (sync2_q != hist_q);

    // Synchronizer, history, fill tracking and registered tick pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            hist_q      <= 1'b0;
            fill_q      <= 3'b000;
            tick_rise_q <= 1'b0;
            tick_fall_q <= 1'b0;
        end else begin
            sync1_q     <= sig_i;
            sync2_q     <= sync1_q;
            hist_q      <= sync2_q;
            fill_q      <= {fill_q[1:0], 1'b1};
            tick_rise_q <= edge_o && sync2_q;
            tick_fall_q <= edge_o && !sync2_q;
        end
    end

    assign tick_rise_o = tick_rise_q;
    assign tick_fall_o = tick_fall_q;

endmodule

// File: rtl/slow_clock_monitor.sv
// Measures slow_clk half-periods in clk cycles and tracks lock against a nominal value.
module slow_clock_monitor
    import slow_clock_monitor_pkg::*;
#(
    parameter int EXPECTED_HALF = 6_250_000,
    parameter int TOL           = 62_500,
    parameter int LOCK_COUNT    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic slow_clk,
    input  logic clr_err,
    slow_clock_monitor_if.master mon
);
    localparam cnt_t LO     = cnt_t'(EXPECTED_HALF - TOL);
    localparam cnt_t HI     = cnt_t'(EXPECTED_HALF + TOL);
    localparam cnt_t SAT    = cnt_t'(EXPECTED_HALF + TOL + 1);
    localparam int   GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);

    mon_state_e        state_q, state_d;
    cnt_t              cnt_q, cnt_d, half_q;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              meas_q, err_fast_q, err_slow_q, lock_lost_q;
    logic              edge_det, tick_rise, tick_fall;
    logic              meas, set_fast, set_slow, set_lost;
    logic              timeout, in_range, is_short;

    sync_edge_detect u_sync (
        .clk         (clk),
        .reset       (reset),
        .sig_i       (slow_clk),
        .edge_o      (edge_det),
        .tick_rise_o (tick_rise),
        .tick_fall_o (tick_fall)
    );

    assign timeout  = (cnt_q == SAT);
    assign in_range = (cnt_q >= LO) && (cnt_q <= HI);
    assign is_short = (cnt_q < LO);

    // Interval counter: restart at 1 on an edge, otherwise count up and hold at saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (edge_det)        cnt_d = cnt_t'(1);
        else if (!timeout)   cnt_d = cnt_q + cnt_t'(1);
    end

    // Next-state and event decode; an edge takes priority over a coincident timeout.
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        meas     = 1'b0;
        set_fast = 1'b0;
        set_slow = 1'b0;
        set_lost = 1'b0;
        case (state_q)
            ACQUIRE: begin
                if (edge_det) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            MEASURE: begin
                if (edge_det) begin
                    meas = 1'b1;
                    if (in_range) begin
                        if (good_q != GOOD_MAX) good_d = good_q + GOOD_W'(1);
                    end else begin
                        good_d   = '0;
                        set_fast = is_short;
                    end
                end else if (timeout) begin
                    set_slow = 1'b1;
                    state_d  = LOST;
                    good_d   = '0;
                end else if (good_q == GOOD_MAX) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (edge_det) begin
                    meas = 1'b1;
                    if (!in_range) begin
                        state_d  = LOST;
                        set_lost = 1'b1;
                        set_fast = is_short;
                        good_d   = '0;
                    end
                end else if (timeout) begin
                    state_d  = LOST;
                    set_slow = 1'b1;
                    set_lost = 1'b1;
                    good_d   = '0;
                end
            end
            LOST: begin
                if (edge_det) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            default: state_d = ACQUIRE;
        endcase
    end

    // State, counter, measurement and sticky flags; a set event beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ACQUIRE;
            cnt_q       <= '0;
            good_q      <= '0;
            half_q      <= '0;
            meas_q      <= 1'b0;
            err_fast_q  <= 1'b0;
            err_slow_q  <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            good_q      <= good_d;
            meas_q      <= meas;
            if (meas) half_q <= cnt_q;
            err_fast_q  <= set_fast | (err_fast_q  & ~clr_err);
            err_slow_q  <= set_slow | (err_slow_q  & ~clr_err);
            lock_lost_q <= set_lost | (lock_lost_q & ~clr_err);
        end
    end

    assign mon.tick_rise   = tick_rise;
    assign mon.tick_fall   = tick_fall;
    assign mon.half_period = half_q;
    assign mon.meas_valid  = meas_q;
    assign mon.locked      = (state_q == LOCKED);
    assign mon.err_fast    = err_fast_q;
    assign mon.err_slow    = err_slow_q;
    assign mon.lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Directed bench for slow_clock_monitor with EXPECTED_HALF=20, TOL=2, LOCK_COUNT=4.
module tb_slow_clock_monitor;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic slow_clk = 1'b0;
    logic clr_err = 1'b0;

    int checks = 0;
    int errors = 0;

    // Event tallies taken just after each rising edge.
    int n_rise = 0, n_fall = 0, n_meas = 0, n_bad = 0;
    int last_hp = 0;

    slow_clock_monitor_if mon ();

    slow_clock_monitor #(
        .EXPECTED_HALF (20),
        .TOL           (2),
        .LOCK_COUNT    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .slow_clk (slow_clk),
        .clr_err  (clr_err),
        .mon      (mon)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (mon.tick_rise) n_rise++;
        if (mon.tick_fall) n_fall++;
        if (mon.meas_valid) begin
            n_meas++;
            last_hp = int'(mon.half_period);
            if (!(mon.tick_rise || mon.tick_fall)) n_bad++;
        end
    end

    // Flip slow_clk at a falling edge of clk, then hold it for n cycles.
    task automatic run_half(input int n);
        slow_clk = ~slow_clk;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({mon.tick_rise, mon.tick_fall, mon.meas_valid, mon.locked} !== 4'b0) begin
            errors++; $display("FAIL reset_pulses got %b exp 0000", {mon.tick_rise, mon.tick_fall, mon.meas_valid, mon.locked});
        end
        checks++;
        if ({mon.err_fast, mon.err_slow, mon.lock_lost} !== 3'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 000", {mon.err_fast, mon.err_slow, mon.lock_lost});
        end
        checks++;
        if (mon.half_period !== 23'd0) begin
            errors++; $display("FAIL reset_half got %0d exp 0", mon.half_period);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (n_rise + n_fall !== 0) begin
            errors++; $display("FAIL reset_no_tick got %0d exp 0", n_rise + n_fall);
        end
    endtask

    task automatic test_lock;
        repeat (4) run_half(20);
        checks++;
        if (n_meas !== 3 || mon.locked !== 1'b0) begin
            errors++; $display("FAIL lock_early got meas=%0d locked=%b exp meas=3 locked=0", n_meas, mon.locked);
        end
        run_half(20);
        checks++;
        if (n_meas !== 4 || mon.locked !== 1'b1) begin
            errors++; $display("FAIL lock_4th got meas=%0d locked=%b exp meas=4 locked=1", n_meas, mon.locked);
        end
        checks++;
        if (last_hp !== 20) begin
            errors++; $display("FAIL lock_half got %0d exp 20", last_hp);
        end
        run_half(20);
        checks++;
        if (n_rise !== 3 || n_fall !== 3 || n_meas !== 5) begin
            errors++; $display("FAIL lock_counts got r=%0d f=%0d m=%0d exp r=3 f=3 m=5", n_rise, n_fall, n_meas);
        end
        checks++;
        if ({mon.err_fast, mon.err_slow, mon.lock_lost} !== 3'b0 || n_bad !== 0) begin
            errors++; $display("FAIL lock_flags got %b bad=%0d exp 000 bad=0", {mon.err_fast, mon.err_slow, mon.lock_lost}, n_bad);
        end
    endtask

    task automatic test_fast;
        int m0;
        run_half(15);
        run_half(20);
        checks++;
        if (last_hp !== 15 || mon.locked !== 1'b0) begin
            errors++; $display("FAIL fast_meas got hp=%0d locked=%b exp hp=15 locked=0", last_hp, mon.locked);
        end
        checks++;
        if ({mon.err_fast, mon.err_slow, mon.lock_lost} !== 3'b101) begin
            errors++; $display("FAIL fast_flags got %b exp 101", {mon.err_fast, mon.err_slow, mon.lock_lost});
        end
        m0 = n_meas;
        repeat (4) run_half(20);
        checks++;
        if (n_meas !== m0 + 3 || mon.locked !== 1'b0) begin
            errors++; $display("FAIL relock_early got meas=%0d locked=%b exp meas=%0d locked=0", n_meas, mon.locked, m0 + 3);
        end
        run_half(20);
        checks++;
        if (n_meas !== m0 + 4 || mon.locked !== 1'b1) begin
            errors++; $display("FAIL relock got meas=%0d locked=%b exp meas=%0d locked=1", n_meas, mon.locked, m0 + 4);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++;
        if ({mon.err_fast, mon.err_slow, mon.lock_lost} !== 3'b000) begin
            errors++; $display("FAIL clr_flags got %b exp 000", {mon.err_fast, mon.err_slow, mon.lock_lost});
        end
    endtask

    task automatic test_slow;
        logic lvl;
        slow_clk = ~slow_clk;
        lvl = slow_clk;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 2) begin
                checks++;
                if ({mon.tick_rise, mon.tick_fall} !== 2'b00) begin
                    errors++; $display("FAIL tick_early got %b exp 00", {mon.tick_rise, mon.tick_fall});
                end
            end
            if (k == 3) begin
                checks++;
                if ({mon.tick_rise, mon.tick_fall} !== {lvl, ~lvl}) begin
                    errors++; $display("FAIL tick_latency got %b exp %b", {mon.tick_rise, mon.tick_fall}, {lvl, ~lvl});
                end
            end
            if (k == 4) begin
                checks++;
                if ({mon.tick_rise, mon.tick_fall} !== 2'b00) begin
                    errors++; $display("FAIL tick_width got %b exp 00", {mon.tick_rise, mon.tick_fall});
                end
            end
            if (k == 25) begin
                checks++;
                if (mon.locked !== 1'b1 || mon.err_slow !== 1'b0) begin
                    errors++; $display("FAIL slow_before got locked=%b err_slow=%b exp 1 0", mon.locked, mon.err_slow);
                end
            end
            if (k == 26) begin
                checks++;
                if (mon.locked !== 1'b0 || mon.err_slow !== 1'b1 || mon.lock_lost !== 1'b1) begin
                    errors++; $display("FAIL slow_timeout got locked=%b err_slow=%b lost=%b exp 0 1 1", mon.locked, mon.err_slow, mon.lock_lost);
                end
            end
        end
        checks++;
        if (dut.cnt_q !== 23'd23) begin
            errors++; $display("FAIL slow_sat got %0d exp 23", dut.cnt_q);
        end
    endtask

    task automatic test_alternating;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        run_half(22);
        run_half(18);
        run_half(22);
        run_half(18);
        run_half(22);
        checks++;
        if (mon.locked !== 1'b1 || last_hp !== 18) begin
            errors++; $display("FAIL alt_lock got locked=%b hp=%0d exp 1 18", mon.locked, last_hp);
        end
        run_half(23);
        run_half(5);
        checks++;
        if (last_hp !== 23 || mon.locked !== 1'b0) begin
            errors++; $display("FAIL alt_23 got hp=%0d locked=%b exp 23 0", last_hp, mon.locked);
        end
        checks++;
        if ({mon.err_fast, mon.err_slow, mon.lock_lost} !== 3'b001) begin
            errors++; $display("FAIL alt_flags got %b exp 001", {mon.err_fast, mon.err_slow, mon.lock_lost});
        end
    endtask

    task automatic test_reset_mid;
        int r0, f0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        slow_clk = 1'b1;
        #1;
        checks++;
        if (mon.half_period !== 23'd0 || mon.lock_lost !== 1'b0 || mon.locked !== 1'b0) begin
            errors++; $display("FAIL mid_reset got hp=%0d lost=%b locked=%b exp 0 0 0", mon.half_period, mon.lock_lost, mon.locked);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        r0 = n_rise;
        f0 = n_fall;
        repeat (10) @(negedge clk);
        checks++;
        if (n_rise !== r0) begin
            errors++; $display("FAIL mid_no_rise got %0d exp %0d", n_rise, r0);
        end
        run_half(20);
        checks++;
        if (n_fall !== f0 + 1 || n_rise !== r0) begin
            errors++; $display("FAIL mid_first_fall got f=%0d r=%0d exp f=%0d r=%0d", n_fall, n_rise, f0 + 1, r0);
        end
        run_half(10);
        slow_clk = ~slow_clk;
        repeat (2) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++;
        if (mon.err_fast !== 1'b1 || last_hp !== 10) begin
            errors++; $display("FAIL clr_collide got err_fast=%b hp=%0d exp 1 10", mon.err_fast, last_hp);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (mon.err_fast !== 1'b1 || mon.locked !== 1'b0) begin
            errors++; $display("FAIL clr_collide_hold got err_fast=%b locked=%b exp 1 0", mon.err_fast, mon.locked);
        end
    endtask

    initial begin
        test_reset;
        test_lock;
        test_fast;
        test_slow;
        test_alternating;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
